// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared constants, FSM encoding and header helper for the DAQ framer
package daq_pkg;

    localparam logic [7:0] DAQ_MAGIC = 8'hDA;
    localparam int         HDR_SEQ_W = 8;
    localparam int         HDR_LEN_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEN_WAIT = 3'd1,
        ST_HDR0     = 3'd2,
        ST_HDR1     = 3'd3,
        ST_PAYLOAD  = 3'd4
    } daq_state_t;

    // Header word 0: magic | seq | more | payload word count
    function automatic logic [31:0] daq_hdr0(input logic [HDR_SEQ_W-1:0] seq,
                                             input logic                 more,
                                             input logic [HDR_LEN_W-1:0] len);
        return {DAQ_MAGIC, seq, more, len};
    endfunction

endpackage

// File: rtl/daq_framer_if.sv
// rtl/daq_framer_if.sv - framed word stream towards the MAC transmitter
interface daq_framer_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;

    modport master (output tx_data, output tx_valid, output tx_sof, output tx_eof, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_sof, input tx_eof, output tx_ready);
endinterface

// File: rtl/daq_skid.sv
// rtl/daq_skid.sv - 2-entry 32-bit skid FIFO with occupancy output
module daq_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head_data,
    output logic [1:0]  occ
);

    logic [31:0] entry0;
    logic [31:0] entry1;
    logic [1:0]  count;
    logic        pop_ok;

    assign pop_ok    = pop && (count != 2'd0);
    assign head_data = entry0;
    assign occ       = count;

    // entry0 is always the head; entry1 holds the second word when two are stored
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/daq_framer.sv
// rtl/daq_framer.sv - pops DAQ packets from length/data FIFOs and emits framed words to the MAC
module daq_framer
    import daq_pkg::*;
#(
    parameter int MAC_PACKET_BITS = 16,
    parameter int MAX_WORDS       = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                systime,
    input  logic [MAC_PACKET_BITS-1:0] daqo_len,
    input  logic                       daqo_len_ready,
    output logic                       daqo_len_rd_en,
    input  logic [31:0]                daqo_data,
    output logic                       daqo_data_rd_en,
    daq_framer_if.master               tx
);

    localparam logic [MAC_PACKET_BITS-1:0] MAX_LEN   = MAC_PACKET_BITS'(MAX_WORDS);
    localparam logic [HDR_LEN_W-1:0]       MAX_FRAME = HDR_LEN_W'(MAX_WORDS);

    daq_state_t                 state;
    daq_state_t                 state_nxt;
    logic [MAC_PACKET_BITS-1:0] remain;
    logic [HDR_SEQ_W-1:0]       seq;
    logic [31:0]                hdr_time;
    logic [HDR_LEN_W-1:0]       words_req;
    logic [HDR_LEN_W-1:0]       words_sent;
    logic                       rd_pending;

    logic [HDR_LEN_W-1:0]       frame_len;
    logic                       more;
    logic                       last_word;
    logic                       accept;
    logic                       skid_pop;
    logic                       fetch_ok;
    logic [2:0]                 occ_eff;
    logic [31:0]                skid_head;
    logic [1:0]                 skid_occ;

    // remain only changes between frames, so the current frame size is a pure function of it
    assign more      = remain > MAX_LEN;
    assign frame_len = more ? MAX_FRAME : HDR_LEN_W'(remain);
    assign last_word = words_sent == (frame_len - 15'd1);
    assign accept    = tx.tx_valid && tx.tx_ready;
    assign skid_pop  = (state == ST_PAYLOAD) && (skid_occ != 2'd0) && tx.tx_ready;

    // Count the slot freed by this cycle's pop so a full-rate stream keeps one read in flight
    assign occ_eff  = {1'b0, skid_occ} - {2'b0, skid_pop} + {2'b0, rd_pending};
    assign fetch_ok = (words_req < frame_len) && (occ_eff < 3'd2);

    daq_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pending),
        .push_data (daqo_data),
        .pop       (skid_pop),
        .head_data (skid_head),
        .occ       (skid_occ)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (daqo_len_ready) state_nxt = ST_LEN_WAIT;
            ST_LEN_WAIT: state_nxt = ST_HDR0;
            ST_HDR0:     if (accept) state_nxt = ST_HDR1;
            ST_HDR1:     if (accept) state_nxt = (frame_len == '0) ? ST_IDLE : ST_PAYLOAD;
            ST_PAYLOAD:  if (accept && last_word) state_nxt = more ? ST_HDR0 : ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Packet bookkeeping: remaining length, sequence number, timestamp and word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            remain     <= '0;
            seq        <= '0;
            hdr_time   <= '0;
            words_req  <= '0;
            words_sent <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= daqo_data_rd_en;
            if (state == ST_LEN_WAIT) remain <= daqo_len;
            if (state == ST_PAYLOAD && accept && last_word)
                remain <= remain - MAC_PACKET_BITS'(frame_len);
            if (state_nxt == ST_HDR0 && state != ST_HDR0) hdr_time <= systime;
            if (accept && tx.tx_eof) seq <= seq + 8'd1;
            if (state == ST_HDR0) begin
                words_req  <= '0;
                words_sent <= '0;
            end else begin
                if (daqo_data_rd_en) words_req  <= words_req + 15'd1;
                if (skid_pop)        words_sent <= words_sent + 15'd1;
            end
        end
    end

    // Outputs decoded from state; payload words come straight from the skid head
    always_comb begin
        daqo_len_rd_en  = 1'b0;
        daqo_data_rd_en = 1'b0;
        tx.tx_valid     = 1'b0;
        tx.tx_data      = '0;
        tx.tx_sof       = 1'b0;
        tx.tx_eof       = 1'b0;
        case (state)
            ST_IDLE: daqo_len_rd_en = daqo_len_ready;
            ST_HDR0: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = daq_hdr0(seq, more, frame_len);
                tx.tx_sof   = 1'b1;
            end
            ST_HDR1: begin
                tx.tx_valid     = 1'b1;
                tx.tx_data      = hdr_time;
                tx.tx_eof       = (frame_len == '0);
                daqo_data_rd_en = fetch_ok;
            end
            ST_PAYLOAD: begin
                tx.tx_valid     = (skid_occ != 2'd0);
                tx.tx_data      = skid_head;
                tx.tx_eof       = last_word;
                daqo_data_rd_en = fetch_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_daq_framer.sv
// tb/tb_daq_framer.sv - self-checking bench for daq_framer
module tb_daq_framer;

    localparam int MPB  = 16;
    localparam int MAXW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    systime = 32'h1000_0000;
    logic [MPB-1:0] daqo_len = '0;
    logic           daqo_len_ready = 1'b0;
    logic           daqo_len_rd_en;
    logic [31:0]    daqo_data = '0;
    logic           daqo_data_rd_en;

    daq_framer_if tx_if ();

    daq_framer #(.MAC_PACKET_BITS(MPB), .MAX_WORDS(MAXW)) dut (
        .clk             (clk),
        .rst             (rst),
        .systime         (systime),
        .daqo_len        (daqo_len),
        .daqo_len_ready  (daqo_len_ready),
        .daqo_len_rd_en  (daqo_len_rd_en),
        .daqo_data       (daqo_data),
        .daqo_data_rd_en (daqo_data_rd_en),
        .tx              (tx_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FIFO models feeding the framer: one-cycle read latency
    logic [31:0] data_q[$];
    int          len_q[$];
    int          len_pops = 0;
    int          data_pops = 0;
    int          underflows = 0;

    always @(posedge clk) begin
        if (rst) begin
            daqo_len_ready <= 1'b0;
        end else begin
            if (daqo_len_rd_en) begin
                len_pops++;
                if (len_q.size() > 0) daqo_len <= MPB'(len_q.pop_front());
                else underflows++;
            end
            if (daqo_data_rd_en) begin
                data_pops++;
                if (data_q.size() > 0) daqo_data <= data_q.pop_front();
                else underflows++;
            end
            daqo_len_ready <= (len_q.size() > 0);
        end
    end

    // MAC side: tx_ready changes just after the rising edge
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_if.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: capture accepted words, check hold-while-stalled, drive systime
    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic [31:0] t;
    } rx_t;
    rx_t         rx_q[$];
    logic [31:0] frame_time = '0;
    bit          pend = 1'b0;
    logic [31:0] pd;
    logic        ps, pe;
    int          cyc = 0;
    int          first_sof_cyc = 0;
    int          last_eof_cyc = 0;
    bit          seen_sof = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("stall_hold", {29'b0, tx_if.tx_valid, tx_if.tx_sof, tx_if.tx_eof},
                      {29'b0, 1'b1, ps, pe});
                check("stall_data", tx_if.tx_data, pd);
            end
            if (tx_if.tx_valid && tx_if.tx_sof && !pend) frame_time = systime;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                rx_q.push_back('{tx_if.tx_data, tx_if.tx_sof, tx_if.tx_eof, frame_time});
                if (tx_if.tx_sof && !seen_sof) begin
                    first_sof_cyc = cyc;
                    seen_sof = 1'b1;
                end
                if (tx_if.tx_eof) last_eof_cyc = cyc;
            end
            pend = tx_if.tx_valid && !tx_if.tx_ready;
            pd = tx_if.tx_data;
            ps = tx_if.tx_sof;
            pe = tx_if.tx_eof;
        end
        systime = systime + 32'd7;
    end

    // Reference model: frame list derived from packet length and MAX_WORDS
    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        bit          is_time;
    } exp_t;
    exp_t exp_q[$];
    int   exp_seq = 0;

    task automatic model_packet(input int len, input logic [31:0] w[$]);
        int rem = len;
        int idx = 0;
        do begin
            int fl = (rem < MAXW) ? rem : MAXW;
            bit mr = (rem > MAXW);
            exp_q.push_back('{{8'hDA, 8'(exp_seq), mr, 15'(fl)}, 1'b1, 1'b0, 1'b0});
            exp_q.push_back('{32'h0, 1'b0, (fl == 0), 1'b1});
            for (int k = 0; k < fl; k++) begin
                exp_q.push_back('{w[idx], 1'b0, (k == fl - 1), 1'b0});
                idx++;
            end
            exp_seq = (exp_seq + 1) % 256;
            rem -= fl;
        end while (rem > 0);
    endtask

    task automatic send_packet(input int len);
        logic [31:0] w[$];
        for (int i = 0; i < len; i++) begin
            logic [31:0] d = $urandom;
            w.push_back(d);
            data_q.push_back(d);
        end
        model_packet(len, w);
        len_q.push_back(len);
    endtask

    task automatic clear_bench();
        rx_q.delete();
        exp_q.delete();
        exp_seq    = 0;
        len_pops   = 0;
        data_pops  = 0;
        underflows = 0;
        seen_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_q.delete();
        len_q.delete();
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        check("rst_len_rd_en", 32'(daqo_len_rd_en), 32'd0);
        check("rst_data_rd_en", 32'(daqo_data_rd_en), 32'd0);
        rst = 1'b0;
        clear_bench();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (rx_q.size() < exp_q.size() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", 32'(n < budget), 32'd1);
        repeat (8) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        check({tag, "_nwords"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (exp_q[i].is_time)
                check($sformatf("%s_hdr1_time[%0d]", tag, i), rx_q[i].data, rx_q[i].t);
            else
                check($sformatf("%s_word[%0d]", tag, i), rx_q[i].data, exp_q[i].data);
            check($sformatf("%s_sof_eof[%0d]", tag, i), {30'b0, rx_q[i].sof, rx_q[i].eof},
                  {30'b0, exp_q[i].sof, exp_q[i].eof});
        end
    endtask

    function automatic int count_sof();
        int c = 0;
        foreach (rx_q[i]) if (rx_q[i].sof) c++;
        return c;
    endfunction

    typedef struct {
        int          len;
        bit          rnd;
        logic [31:0] exp_w0;
        int          exp_frames;
        int          exp_words;
        int          exp_pops;
        int          exp_span;
    } vec_t;

    vec_t vecs[6];

    initial begin
        tx_if.tx_ready = 1'b0;
        vecs[0] = '{3,  1'b0, 32'hDA00_0003, 1,  5,  3,  6};
        vecs[1] = '{0,  1'b0, 32'hDA00_0000, 1,  2,  0,  2};
        vecs[2] = '{10, 1'b0, 32'hDA00_8004, 3,  16, 10, 0};
        vecs[3] = '{4,  1'b0, 32'hDA00_0004, 1,  6,  4,  7};
        vecs[4] = '{5,  1'b1, 32'hDA00_8004, 2,  9,  5,  0};
        vecs[5] = '{64, 1'b1, 32'hDA00_8004, 16, 96, 64, 0};

        for (int v = 0; v < 6; v++) begin
            string tag = $sformatf("v%0d_len%0d", v, vecs[v].len);
            rand_ready = 1'b0;
            do_reset();
            rand_ready = vecs[v].rnd;
            send_packet(vecs[v].len);
            wait_done(3000);
            compare_stream(tag);
            check({tag, "_w0"}, (rx_q.size() > 0) ? rx_q[0].data : 32'hxxxx_xxxx, vecs[v].exp_w0);
            check({tag, "_frames"}, 32'(count_sof()), 32'(vecs[v].exp_frames));
            check({tag, "_words"}, 32'(rx_q.size()), 32'(vecs[v].exp_words));
            check({tag, "_data_pops"}, 32'(data_pops), 32'(vecs[v].exp_pops));
            check({tag, "_len_pops"}, 32'(len_pops), 32'd1);
            check({tag, "_underflow"}, 32'(underflows), 32'd0);
            if (vecs[v].exp_span > 0)
                check({tag, "_span"}, 32'(last_eof_cyc - first_sof_cyc + 1), 32'(vecs[v].exp_span));
        end

        // Two packets queued back-to-back
        rand_ready = 1'b0;
        do_reset();
        send_packet(1);
        send_packet(2);
        wait_done(2000);
        compare_stream("b2b");
        check("b2b_len_pops", 32'(len_pops), 32'd2);
        check("b2b_data_pops", 32'(data_pops), 32'd3);
        check("b2b_frames", 32'(count_sof()), 32'd2);

        // Reset in the middle of a payload
        do_reset();
        rand_ready = 1'b1;
        send_packet(10);
        begin
            int n = 0;
            while (rx_q.size() < 3 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("midrst_reached_payload", 32'(n < 2000), 32'd1);
        end
        rst = 1'b1;
        data_q.delete();
        len_q.delete();
        @(posedge clk);
        #1;
        check("midrst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        check("midrst_len_rd_en", 32'(daqo_len_rd_en), 32'd0);
        check("midrst_data_rd_en", 32'(daqo_data_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_bench();
        rand_ready = 1'b0;
        send_packet(1);
        wait_done(2000);
        compare_stream("postrst");
        check("postrst_w0_seq0", (rx_q.size() > 0) ? rx_q[0].data : 32'hxxxx_xxxx, 32'hDA00_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
